// File: rtl/riscv_pkg.sv
// Shared integer-pipeline types: the default data width, the register address type and
// the write-back source encoding.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NUM_REGS     = 32;

  typedef logic [4:0] regaddr_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  // On a tie, the source that was not served last time gets the grant.
  function automatic logic alu_wins(input logic alu_valid, input logic mem_valid,
                                    input wb_src_e last_grant);
    return alu_valid && (!mem_valid || (last_grant == WB_MEM));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for x1..x31. The issue-side set has priority over both flush
// and commit-side clear, so a re-issued destination is never lost.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_en,
  input  regaddr_t set_idx,
  input  logic     clr_en,
  input  regaddr_t clr_idx,
  input  logic     flush,
  input  regaddr_t rs1,
  input  regaddr_t rs2,
  output logic     rs1_pend,
  output logic     rs2_pend
);

  logic [NUM_REGS-1:1] pending_q;
  logic [NUM_REGS-1:1] pending_d;
  logic [NUM_REGS-1:0] pending_full;

  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (set_en && (set_idx == regaddr_t'(i))) begin
        pending_d[i] = 1'b1;
      end else if (flush || (clr_en && (clr_idx == regaddr_t'(i)))) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // x0 reads as a permanent zero so it can never stall decode.
  assign pending_full = {pending_q, 1'b0};
  assign rs1_pend     = pending_full[rs1];
  assign rs2_pend     = pending_full[rs2];

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port: round-robin ALU/load arbitration, one registered write per cycle,
// and RAW hazard reporting. Optional feature macro: REG_WRITEBACK_BYPASS_EN (forwarding outputs).
module reg_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic            flush,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
`ifdef REG_WRITEBACK_BYPASS_EN
  output logic            byp_rs1_hit,
  output logic            byp_rs2_hit,
  output logic [XLEN-1:0] byp_data,
`endif
  output logic            rd_w,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_in
);

  wb_src_e         last_grant;
  logic            grant_any;
  regaddr_t        sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            rs1_pend;
  logic            rs2_pend;

  always_comb begin
    alu_ready = alu_wins(alu_valid, mem_valid, last_grant);
    mem_ready = mem_valid && !alu_ready;
    grant_any = alu_ready || mem_ready;
    sel_rd    = alu_ready ? alu_rd : mem_rd;
    sel_data  = alu_ready ? alu_data : mem_data;
  end

  // Reset to MEM so the ALU takes the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= WB_MEM;
    end else if (grant_any) begin
      last_grant <= alu_ready ? WB_ALU : WB_MEM;
    end
  end

  // Writes to x0 are consumed from the source but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_w  <= 1'b0;
      rd    <= '0;
      rd_in <= '0;
    end else begin
      rd_w <= grant_any && (sel_rd != '0);
      if (grant_any) begin
        rd    <= sel_rd;
        rd_in <= sel_data;
      end
    end
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_valid),
    .set_idx  (iss_rd),
    .clr_en   (rd_w),
    .clr_idx  (rd),
    .flush    (flush),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend)
  );

`ifdef REG_WRITEBACK_BYPASS_EN
  // A write on the port this cycle can be forwarded, so it no longer has to stall decode.
  assign byp_rs1_hit = rd_w && (rs1 != '0) && (rs1 == rd);
  assign byp_rs2_hit = rd_w && (rs2 != '0) && (rs2 == rd);
  assign byp_data    = rd_in;
  assign rs1_busy    = rs1_pend && !byp_rs1_hit;
  assign rs2_busy    = rs2_pend && !byp_rs2_hit;
`else
  assign rs1_busy = rs1_pend;
  assign rs2_busy = rs2_pend;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, arbitration, latency, x0 handling, scoreboard
// set/clear/flush priority, and forwarding when REG_WRITEBACK_BYPASS_EN is defined.
module tb_reg_writeback;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            flush;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_w;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_in;
`ifdef REG_WRITEBACK_BYPASS_EN
  logic            byp_rs1_hit;
  logic            byp_rs2_hit;
  logic [XLEN-1:0] byp_data;
`endif

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  reg_writeback #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .flush       (flush),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
`ifdef REG_WRITEBACK_BYPASS_EN
    .byp_rs1_hit (byp_rs1_hit),
    .byp_rs2_hit (byp_rs2_hit),
    .byp_data    (byp_data),
`endif
    .rd_w        (rd_w),
    .rd          (rd),
    .rd_in       (rd_in)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rs1 = 5'd1; rs2 = 5'd2;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_rd_w", 32'(rd_w), 32'd0);
    checkOutput("reset_rd", 32'(rd), 32'd0);
    checkOutput("reset_rd_in", rd_in, 32'd0);
    checkOutput("reset_rs1_busy", 32'(rs1_busy), 32'd0);
    rst_n = 1'b1;

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; rs1 = 5'd5;
    #1;
    checkOutput("alu_only_ready", 32'(alu_ready), 32'd1);
    checkOutput("alu_only_mem_ready", 32'(mem_ready), 32'd0);
    applyStimulus();
    alu_valid = 1'b0;
    checkOutput("alu_only_rd_w", 32'(rd_w), 32'd1);
    checkOutput("alu_only_rd", 32'(rd), 32'd5);
    checkOutput("alu_only_rd_in", rd_in, 32'hDEADBEEF);

    // x0 destination: consumed but never written, never busy
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1;
    iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    #1;
    checkOutput("x0_mem_ready", 32'(mem_ready), 32'd1);
    applyStimulus();
    mem_valid = 1'b0; iss_valid = 1'b0;
    checkOutput("x0_rd_w", 32'(rd_w), 32'd0);
    checkOutput("x0_rs1_busy", 32'(rs1_busy), 32'd0);

    // Contention: last grant was MEM, so ALU, MEM, ALU
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB4;
    #1;
    checkOutput("rr1_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("rr1_mem_ready", 32'(mem_ready), 32'd0);
    applyStimulus();
    alu_data = 32'hA33;
    checkOutput("rr1_rd", 32'(rd), 32'd3);
    checkOutput("rr1_rd_in", rd_in, 32'hA3);
    #1;
    checkOutput("rr2_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("rr2_alu_ready", 32'(alu_ready), 32'd0);
    applyStimulus();
    mem_data = 32'hB44;
    checkOutput("rr2_rd", 32'(rd), 32'd4);
    checkOutput("rr2_rd_in", rd_in, 32'hB4);
    #1;
    checkOutput("rr3_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("rr3_mem_ready", 32'(mem_ready), 32'd0);
    applyStimulus();
    alu_valid = 1'b0;
    checkOutput("rr3_rd_in", rd_in, 32'hA33);
    #1;
    checkOutput("rr4_mem_ready", 32'(mem_ready), 32'd1);
    applyStimulus();
    mem_valid = 1'b0;
    checkOutput("rr4_rd", 32'(rd), 32'd4);
    checkOutput("rr4_rd_in", rd_in, 32'hB44);
    applyStimulus();
    checkOutput("idle_rd_w", 32'(rd_w), 32'd0);

    // Scoreboard set then clear on commit
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    applyStimulus();
    iss_valid = 1'b0;
    checkOutput("sb_busy_after_iss", 32'(rs1_busy), 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    applyStimulus();
    alu_valid = 1'b0;
    checkOutput("sb_commit_rd_w", 32'(rd_w), 32'd1);
    checkOutput("sb_commit_rd", 32'(rd), 32'd7);
`ifdef REG_WRITEBACK_BYPASS_EN
    checkOutput("sb_commit_busy", 32'(rs1_busy), 32'd0);
    checkOutput("sb_commit_byp_hit", 32'(byp_rs1_hit), 32'd1);
    checkOutput("sb_commit_byp_data", byp_data, 32'h77);
`else
    checkOutput("sb_commit_busy", 32'(rs1_busy), 32'd1);
`endif
    applyStimulus();
    checkOutput("sb_cleared", 32'(rs1_busy), 32'd0);

    // Re-issue in the commit cycle: set wins
    iss_valid = 1'b1; iss_rd = 5'd7;
    applyStimulus();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    applyStimulus();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    applyStimulus();
    iss_rd = 5'd12; rs2 = 5'd12;
    checkOutput("sb_set_wins_rd_w", 32'(rd_w), 32'd0);
    checkOutput("sb_set_wins_busy", 32'(rs1_busy), 32'd1);
    applyStimulus();
    iss_valid = 1'b0;
    checkOutput("sb_rs2_12_busy", 32'(rs2_busy), 32'd1);

    // Flush with concurrent issue of x9
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
    applyStimulus();
    flush = 1'b0; iss_valid = 1'b0;
    checkOutput("flush_rs1_7", 32'(rs1_busy), 32'd0);
    checkOutput("flush_rs2_12", 32'(rs2_busy), 32'd0);
    rs1 = 5'd9;
    #1;
    checkOutput("flush_rs1_9", 32'(rs1_busy), 32'd1);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99; rs2 = 5'd9;
    applyStimulus();
    mem_valid = 1'b0;
    checkOutput("flush_commit_rd", 32'(rd), 32'd9);
`ifdef REG_WRITEBACK_BYPASS_EN
    checkOutput("flush_byp_rs2_hit", 32'(byp_rs2_hit), 32'd1);
    checkOutput("flush_commit_rs2_busy", 32'(rs2_busy), 32'd0);
`else
    checkOutput("flush_commit_rs2_busy", 32'(rs2_busy), 32'd1);
`endif
    applyStimulus();
    checkOutput("flush_cleared_rs2", 32'(rs2_busy), 32'd0);

    // Reset while a write is on the port
    iss_valid = 1'b1; iss_rd = 5'd11; rs1 = 5'd11;
    applyStimulus();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h1111;
    applyStimulus();
    alu_valid = 1'b0;
    checkOutput("midrst_pre_rd_w", 32'(rd_w), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rd_w", 32'(rd_w), 32'd0);
    checkOutput("midrst_rd", 32'(rd), 32'd0);
    checkOutput("midrst_rd_in", rd_in, 32'd0);
    checkOutput("midrst_busy", 32'(rs1_busy), 32'd0);
    applyStimulus();
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h5;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h6;
    #1;
    checkOutput("postrst_alu_first", 32'(alu_ready), 32'd1);
    checkOutput("postrst_mem_wait", 32'(mem_ready), 32'd0);
    applyStimulus();
    alu_valid = 1'b0; mem_valid = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
